// File: rtl/rs_pkg.sv
// Shared reservation-station / CDB definitions: tag encoding, CDB source map
// and the broadcast payload layout.
package rs_pkg;

    localparam int unsigned ROB_WIDTH      = 4;
    localparam int unsigned CDB_DATA_WIDTH = 32;

    // Tag 0 marks "no dependency" and never appears on the CDB.
    localparam logic [ROB_WIDTH-1:0] TAG_NONE = '0;

    localparam int unsigned NUM_CDB_SRC   = 3;
    localparam int unsigned CDB_SRC_ALU   = 0;
    localparam int unsigned CDB_SRC_LOAD  = 1;
    localparam int unsigned CDB_SRC_STORE = 2;

    typedef struct packed {
        logic [ROB_WIDTH-1:0]      tag;
        logic [CDB_DATA_WIDTH-1:0] value;
    } cdb_entry_t;

    // True when a tag names a real ROB entry.
    function automatic logic is_real_tag(input logic [ROB_WIDTH-1:0] tag);
        return tag != TAG_NONE;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Two-entry result buffer for one CDB producer. The caller only pushes when
// count < 2 and only pops when count > 0; both are re-checked here so the
// pointers can never run past each other.
module cdb_src_fifo #(
    parameter int unsigned W = 36
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [1:0]   o_count,
    output logic [W-1:0] o_head
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    logic         w_push;
    logic         w_pop;

    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = i_pop  && (r_count != 2'd0);

    // Storage, pointers and occupancy; flush empties without touching data.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from each functional unit in a
// small per-source FIFO and broadcasts one per cycle, chosen round-robin.
// Optional build macro CDB_STATS_EN adds saturating broadcast/stall counters.
module cdb_arbiter #(
    parameter int unsigned NUM_SRC    = rs_pkg::NUM_CDB_SRC,
    parameter int unsigned ROB_WIDTH  = rs_pkg::ROB_WIDTH,
    parameter int unsigned DATA_WIDTH = rs_pkg::CDB_DATA_WIDTH
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          rdy_in,
    input  logic                          flush_in,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*ROB_WIDTH-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_value,
    output logic                          cdb_valid,
    output logic [ROB_WIDTH-1:0]          cdb_tag,
    output logic [DATA_WIDTH-1:0]         cdb_value
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]                   stat_bcast,
    output logic [31:0]                   stat_stall
`endif
);

    import rs_pkg::TAG_NONE;

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned ENT_W = ROB_WIDTH + DATA_WIDTH;

    logic                 w_active;
    logic [NUM_SRC-1:0]   w_ready;
    logic [NUM_SRC-1:0]   w_push;
    logic [NUM_SRC-1:0]   w_pop;
    logic [NUM_SRC-1:0]   w_nonempty;
    logic [NUM_SRC-1:0]   w_tag_ok;
    logic [1:0]           w_count [NUM_SRC];
    logic [ENT_W-1:0]     w_head  [NUM_SRC];

    logic                 w_found;
    logic [PTR_W-1:0]     w_gnt;
    logic [PTR_W-1:0]     w_idx;
    logic [ENT_W-1:0]     w_gnt_head;

    logic                 r_cdb_valid;
    logic [ROB_WIDTH-1:0] r_cdb_tag;
    logic [DATA_WIDTH-1:0] r_cdb_value;
    logic [PTR_W-1:0]     r_rr_ptr;

    // Pushes and pops only happen on enabled, non-flush edges.
    assign w_active = rdy_in && !flush_in;

    generate
        for (genvar gi = 0; gi < int'(NUM_SRC); gi++) begin : g_src
            assign w_tag_ok[gi]   = src_tag[gi*ROB_WIDTH +: ROB_WIDTH] != ROB_WIDTH'(TAG_NONE);
            // Ready follows registered occupancy only, never this cycle's grant.
            assign w_ready[gi]    = rst_n && (w_count[gi] < 2'd2);
            assign w_push[gi]     = w_active && src_valid[gi] && w_ready[gi] && w_tag_ok[gi];
            assign w_nonempty[gi] = w_count[gi] != 2'd0;

            cdb_src_fifo #(
                .W (ENT_W)
            ) u_fifo (
                .clk_in  (clk_in),
                .rst_n   (rst_n),
                .i_push  (w_push[gi]),
                .i_pop   (w_pop[gi]),
                .i_flush (rdy_in && flush_in),
                .i_data  ({src_tag[gi*ROB_WIDTH +: ROB_WIDTH],
                           src_value[gi*DATA_WIDTH +: DATA_WIDTH]}),
                .o_count (w_count[gi]),
                .o_head  (w_head[gi])
            );

            // A producer handing over tag 0 is a pipeline bug; the push is dropped.
            a_no_tag_none : assert property (
                @(posedge clk_in) disable iff (!rst_n)
                (w_active && src_valid[gi] && w_ready[gi]) |-> w_tag_ok[gi]
            ) else $error("cdb_arbiter: source %0d pushed reserved tag 0", gi);
        end
    endgenerate

    assign src_ready = w_ready;

    // Round-robin scan starting just after the last winner.
    always_comb begin
        w_found    = 1'b0;
        w_gnt      = r_rr_ptr;
        w_idx      = '0;
        w_gnt_head = '0;
        w_pop      = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            w_idx = PTR_W'((32'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_found && w_nonempty[w_idx]) begin
                w_found      = 1'b1;
                w_gnt        = w_idx;
                w_gnt_head   = w_head[w_idx];
                w_pop[w_idx] = w_active;
            end
        end
    end

    // Broadcast register and round-robin pointer; flush beats grant.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_value <= '0;
            r_rr_ptr    <= PTR_W'(NUM_SRC - 1);
        end else if (rdy_in) begin
            if (flush_in) begin
                r_cdb_valid <= 1'b0;
            end else if (w_found) begin
                r_cdb_valid <= 1'b1;
                r_cdb_tag   <= w_gnt_head[ENT_W-1 -: ROB_WIDTH];
                r_cdb_value <= w_gnt_head[DATA_WIDTH-1:0];
                r_rr_ptr    <= w_gnt;
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_value = r_cdb_value;

`ifdef CDB_STATS_EN
    logic [31:0] r_stat_bcast;
    logic [31:0] r_stat_stall;
    logic        w_stall;

    assign w_stall = |(src_valid & ~w_ready);

    // Saturating activity counters; flush does not clear them.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_bcast <= '0;
            r_stat_stall <= '0;
        end else if (rdy_in) begin
            if (!flush_in && w_found && (r_stat_bcast != '1)) begin
                r_stat_bcast <= r_stat_bcast + 32'd1;
            end
            if (w_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_bcast = r_stat_bcast;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Producer end of the wake-up path: collects results from functional units (ALU, load unit, store/branch unit) and broadcasts one per cycle on the common data bus (CDB).
- RS entries use each broadcast to clear their pending Qj/Qk/Ql/Qm tags. The ROB uses it to mark entries complete.
- Per-source 2-entry buffering and round-robin arbitration guarantee fairness and that no result is lost.
- Tag 0 is reserved: it means "no dependency" and is never broadcast.

Parameters:
- NUM_SRC, 3, number of producing units (index 0 = ALU, 1 = load, 2 = store/branch).
- ROB_WIDTH, 4, tag width; valid tags are 1..2^ROB_WIDTH-1.
- DATA_WIDTH, 32, result width.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global enable; when low, all state holds.
- flush_in  input  1  misprediction flush; discards all buffered results.
- src_valid  input  NUM_SRC  per-source result valid.
- src_ready  output  NUM_SRC  per-source buffer can accept.
- src_tag  input  NUM_SRC*ROB_WIDTH  packed ROB tags; source i occupies bits [i*ROB_WIDTH +: ROB_WIDTH].
- src_value  input  NUM_SRC*DATA_WIDTH  packed result values, same packing.
- cdb_valid  output  1  broadcast valid.
- cdb_tag  output  ROB_WIDTH  broadcast ROB tag.
- cdb_value  output  DATA_WIDTH  broadcast value.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - cdb_valid=0, cdb_tag=0, cdb_value=0.
  - All FIFOs empty.
  - rr_ptr=NUM_SRC-1, so source 0 has first priority.
  - src_ready forced to 0 while rst_n is low.
- src_ready[i] = (count[i] < 2). It depends only on registered count and never combinationally on this cycle's grant.
- Push: on an edge with rdy_in && !flush_in && src_valid[i] && src_ready[i], the tag and value are written to the tail of FIFO i.
  - A push with tag 0 is dropped; this is a simulation assertion error.
- Arbitration, each edge with rdy_in && !flush_in:
  - Scan sources starting at rr_ptr+1, wrapping modulo NUM_SRC.
  - The first non-empty FIFO g wins. Its head is popped and registered onto cdb_* with cdb_valid=1, and rr_ptr<=g.
  - If no FIFO is non-empty, cdb_valid<=0. cdb_tag and cdb_value are don't-care but hold their values.
- Latency: a result pushed at edge N is broadcast, at the earliest, in the cycle after edge N+1. The value comes from the FIFO only; there is no bypass.
- Simultaneous push and pop on the same FIFO is legal; count is unchanged.
  - At count==2, src_ready was low, so no push can occur even if a pop happens that edge.
- Flush (flush_in high at an edge with rdy_in):
  - All counts are cleared and cdb_valid<=0.
  - Pushes that edge are ignored. rr_ptr is unchanged.
  - Flush has priority over push and grant.
- rdy_in low: FIFOs, rr_ptr and cdb_* all hold. The cdb_valid level is repeated, which is idempotent for consumers that are also stalled.
- Reset mid-operation: everything returns to reset values asynchronously, and buffered results are lost.

Optional Feature:
- Macro: CDB_STATS_EN.
- Defined: adds output ports stat_bcast (32) and stat_stall (32).
  - stat_bcast increments on each edge that broadcasts.
  - stat_stall increments on each edge where any src_valid&&!src_ready.
  - Both are gated by rdy_in, saturate at all-ones, and reset to 0. They are not cleared by flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (rs_pkg, with the other RS helpers):
  - ROB_WIDTH.
  - TAG_NONE = 0.
  - NUM_CDB_SRC = 3.
  - Source index constants CDB_SRC_ALU = 0, CDB_SRC_LOAD = 1, CDB_SRC_STORE = 2.
  - A packed cdb_entry_t {tag, value} struct.
- One sub-module: cdb_src_fifo, a 2-entry FIFO with push, pop, flush, count and head outputs, instantiated NUM_SRC times by generate.
- The round-robin scan stays inline.

Test Plan:
1. ALU pushes tag 5, value 0xDEADBEEF at edge 1 → cdb_valid=1, tag 5, value 0xDEADBEEF after edge 2; cdb_valid=0 after edge 3.
2. All three sources push tags 1, 2, 3 in the same cycle after reset → broadcast order 1, 2, 3 on consecutive cycles. Then pushing tags 4, 5, 6 together continues the round-robin from source 0: order 4, 5, 6.
3. All sources push every cycle for 30 cycles → src_ready drops per source. Every accepted tag is broadcast exactly once, with no loss or duplication, and each source gets a 10±1 grant share.
4. Load FIFO holds 2 entries, flush_in pulses while load pushes tag 7 → cdb_valid=0 next cycle, tag 7 and the buffered entries are never broadcast, and src_ready[1]=1.
5. rdy_in held low 5 cycles while cdb shows tag 9 with entries pending → cdb_tag stays 9 and counts are unchanged. Order resumes correctly when rdy_in returns high.
6. With CDB_STATS_EN defined, scenario 3 → stat_bcast equals the total number of accepted pushes, stat_stall is greater than 0, and both are 0 after rst_n is pulsed low.
